// File: rtl/fetch_decode_pipe_reg.sv
// Fetch->Decode pipeline register: main entry M drives decode, skid entry S absorbs
// the one word accepted while decode stalls, so in_ready can come straight from a flop.
module fetch_decode_pipe_reg #(
    parameter int                 INSTR_W   = 16,
    parameter int                 PC_W      = 16,
    parameter logic [INSTR_W-1:0] NOP_INSTR = '0,
    parameter int                 CNT_W     = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [PC_W-1:0]    in_pc,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [PC_W-1:0]    out_pc,
    output logic [CNT_W-1:0]   stall_cnt
);

    logic               m_valid_q, m_valid_d;
    logic [INSTR_W-1:0] m_instr_q, m_instr_d;
    logic [PC_W-1:0]    m_pc_q,    m_pc_d;
    logic               s_valid_q, s_valid_d;
    logic [INSTR_W-1:0] s_instr_q, s_instr_d;
    logic [PC_W-1:0]    s_pc_q,    s_pc_d;
    logic [CNT_W-1:0]   stall_q,   stall_d;

    logic accept;
    logic deliver;

    // in_ready depends only on skid occupancy, never on out_ready
    assign in_ready = !s_valid_q;
    assign accept   = in_valid && !s_valid_q;
    assign deliver  = m_valid_q && out_ready;

    always_comb begin
        m_valid_d = m_valid_q;
        m_instr_d = m_instr_q;
        m_pc_d    = m_pc_q;
        s_valid_d = s_valid_q;
        s_instr_d = s_instr_q;
        s_pc_d    = s_pc_q;

        if (flush) begin
            m_valid_d = 1'b0;
            s_valid_d = 1'b0;
        end else if (deliver) begin
            if (s_valid_q) begin
                m_valid_d = 1'b1;
                m_instr_d = s_instr_q;
                m_pc_d    = s_pc_q;
                s_valid_d = accept;
                if (accept) begin
                    s_instr_d = in_instr;
                    s_pc_d    = in_pc;
                end
            end else begin
                m_valid_d = accept;
                if (accept) begin
                    m_instr_d = in_instr;
                    m_pc_d    = in_pc;
                end
            end
        end else if (!m_valid_q) begin
            if (accept) begin
                m_valid_d = 1'b1;
                m_instr_d = in_instr;
                m_pc_d    = in_pc;
            end
        end else if (accept) begin
            // decode is stalled on M: the new word parks behind it in S
            s_valid_d = 1'b1;
            s_instr_d = in_instr;
            s_pc_d    = in_pc;
        end
    end

    always_comb begin
        stall_d = stall_q;
        if (m_valid_q && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid_q <= 1'b0;
            m_instr_q <= '0;
            m_pc_q    <= '0;
            s_valid_q <= 1'b0;
            s_instr_q <= '0;
            s_pc_q    <= '0;
            stall_q   <= '0;
        end else begin
            m_valid_q <= m_valid_d;
            m_instr_q <= m_instr_d;
            m_pc_q    <= m_pc_d;
            s_valid_q <= s_valid_d;
            s_instr_q <= s_instr_d;
            s_pc_q    <= s_pc_d;
            stall_q   <= stall_d;
        end
    end

    assign out_valid = m_valid_q;
    assign out_instr = m_valid_q ? m_instr_q : NOP_INSTR;
    assign out_pc    = m_valid_q ? m_pc_q : '0;
    assign stall_cnt = stall_q;

endmodule

// File: tb/tb_fetch_decode_pipe_reg.sv
// Bench for fetch_decode_pipe_reg: directed scenarios plus a random run, all checked
// against a queue-based reference model of the register's contents.
module tb_fetch_decode_pipe_reg;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_instr;
    logic [15:0] in_pc;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_instr;
    logic [15:0] out_pc;
    logic [15:0] stall_cnt;

    logic        in_ready2;
    logic        out_valid2;
    logic [15:0] out_instr2;
    logic [15:0] out_pc2;
    logic [1:0]  stall_cnt2;

    fetch_decode_pipe_reg u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
        .stall_cnt(stall_cnt)
    );

    fetch_decode_pipe_reg #(.CNT_W(2)) u_dut_sat (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready2), .in_instr(in_instr), .in_pc(in_pc),
        .flush(flush),
        .out_valid(out_valid2), .out_ready(out_ready), .out_instr(out_instr2), .out_pc(out_pc2),
        .stall_cnt(stall_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] instr;
        logic [15:0] pc;
    } ent_t;

    ent_t q_m[$];      // words held by the register, oldest first
    int   stall_m;
    int   n_checks;
    int   n_pass;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    endtask

    task automatic compare_all(input string tag);
        logic        e_v;
        logic [15:0] e_i;
        logic [15:0] e_p;
        int          e_s2;
        e_v  = (q_m.size() > 0);
        e_i  = e_v ? q_m[0].instr : 16'h0000;
        e_p  = e_v ? q_m[0].pc : 16'h0000;
        e_s2 = (stall_m > 3) ? 3 : stall_m;
        check_eq({tag, "_out_valid"}, 32'(out_valid), 32'(e_v));
        check_eq({tag, "_out_instr"}, 32'(out_instr), 32'(e_i));
        check_eq({tag, "_out_pc"},    32'(out_pc),    32'(e_p));
        check_eq({tag, "_in_ready"},  32'(in_ready),  32'(q_m.size() < 2));
        check_eq({tag, "_stall_cnt"}, 32'(stall_cnt), 32'(stall_m));
        check_eq({tag, "_stall_sat"}, 32'(stall_cnt2), 32'(e_s2));
        check_eq({tag, "_sat_instr"}, 32'(out_instr2), 32'(e_i));
    endtask

    // Drive one cycle of inputs (called just after a falling edge), advance the model,
    // then check the registered result at the next falling edge.
    task automatic cycle(input logic v, input logic [15:0] ins, input logic [15:0] pc,
                         input logic ordy, input logic fl, input string tag);
        logic acc;
        logic dlv;
        ent_t e;
        in_valid  = v;
        in_instr  = ins;
        in_pc     = pc;
        out_ready = ordy;
        flush     = fl;
        #1;
        acc = v && (q_m.size() < 2);
        dlv = (q_m.size() > 0) && ordy;
        if ((q_m.size() > 0) && !ordy && (stall_m < 65535)) stall_m++;
        if (dlv) $display("%s: deliver instr=%h pc=%h", tag, q_m[0].instr, q_m[0].pc);
        if (fl) begin
            q_m.delete();
        end else begin
            if (dlv) void'(q_m.pop_front());
            if (acc) begin
                e.instr = ins;
                e.pc    = pc;
                q_m.push_back(e);
            end
        end
        @(posedge clk);
        @(negedge clk);
        compare_all(tag);
    endtask

    task automatic mid_reset(input string tag);
        #2 rst = 1'b1;
        #1;
        check_eq({tag, "_rst_out_valid"}, 32'(out_valid), 32'h0);
        check_eq({tag, "_rst_out_instr"}, 32'(out_instr), 32'h0000);
        check_eq({tag, "_rst_out_pc"},    32'(out_pc),    32'h0000);
        check_eq({tag, "_rst_in_ready"},  32'(in_ready),  32'h1);
        check_eq({tag, "_rst_stall"},     32'(stall_cnt), 32'h0);
        q_m.delete();
        stall_m = 0;
        @(negedge clk);
        rst = 1'b0;
        $display("%s: reset applied", tag);
        compare_all(tag);
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        stall_m   = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_instr  = '0;
        in_pc     = '0;
        out_ready = 1'b0;
        flush     = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        compare_all("reset");

        // stream, no bubbles
        cycle(1'b1, 16'h1234, 16'd0, 1'b1, 1'b0, "t2");
        check_eq("t2_w0", 32'(out_instr), 32'h1234);
        cycle(1'b1, 16'hABCD, 16'd2, 1'b1, 1'b0, "t2");
        check_eq("t2_w1", 32'(out_instr), 32'hABCD);
        check_eq("t2_w1_pc", 32'(out_pc), 32'd2);
        cycle(1'b1, 16'h3241, 16'd4, 1'b1, 1'b0, "t2");
        check_eq("t2_w2", 32'(out_instr), 32'h3241);
        cycle(1'b0, 16'h0000, 16'd0, 1'b1, 1'b0, "t2");
        check_eq("t2_empty", 32'(out_valid), 32'h0);

        // backpressure into the skid entry
        cycle(1'b1, 16'h1234, 16'd0, 1'b0, 1'b0, "t3");
        cycle(1'b1, 16'hABCD, 16'd2, 1'b0, 1'b0, "t3");
        check_eq("t3_ready_low", 32'(in_ready), 32'h0);
        cycle(1'b1, 16'h3241, 16'd4, 1'b0, 1'b0, "t3");
        check_eq("t3_hold", 32'(out_instr), 32'h1234);
        cycle(1'b0, 16'h0000, 16'd0, 1'b1, 1'b0, "t3");
        check_eq("t3_second", 32'(out_instr), 32'hABCD);
        check_eq("t3_ready_back", 32'(in_ready), 32'h1);
        cycle(1'b0, 16'h0000, 16'd0, 1'b1, 1'b0, "t3");

        // flush while full, and flush dropping an accepted word
        cycle(1'b1, 16'h1234, 16'd0, 1'b0, 1'b0, "t4");
        cycle(1'b1, 16'hABCD, 16'd2, 1'b0, 1'b0, "t4");
        cycle(1'b1, 16'h3241, 16'd4, 1'b0, 1'b1, "t4");
        check_eq("t4_flush_valid", 32'(out_valid), 32'h0);
        check_eq("t4_flush_nop", 32'(out_instr), 32'h0000);
        cycle(1'b1, 16'h1234, 16'd0, 1'b1, 1'b0, "t4");
        cycle(1'b1, 16'h5555, 16'd6, 1'b1, 1'b1, "t4");
        check_eq("t4_drop", 32'(out_valid), 32'h0);
        cycle(1'b0, 16'h0000, 16'd0, 1'b1, 1'b0, "t4");

        // reset asserted mid-cycle while full
        cycle(1'b1, 16'h1111, 16'd8,  1'b0, 1'b0, "t1");
        cycle(1'b1, 16'h2222, 16'd10, 1'b0, 1'b0, "t1");
        mid_reset("t1");

        // stall counter and its saturation at CNT_W=2
        cycle(1'b1, 16'h7777, 16'd12, 1'b0, 1'b0, "t5");
        for (int i = 0; i < 5; i++) cycle(1'b0, 16'h0000, 16'd0, 1'b0, 1'b0, "t5");
        check_eq("t5_stall5", 32'(stall_cnt), 32'd5);
        check_eq("t5_sat_at5", 32'(stall_cnt2), 32'd3);
        cycle(1'b0, 16'h0000, 16'd0, 1'b0, 1'b0, "t5");
        check_eq("t5_stall6", 32'(stall_cnt), 32'd6);
        check_eq("t5_sat_at6", 32'(stall_cnt2), 32'd3);
        cycle(1'b0, 16'h0000, 16'd0, 1'b1, 1'b0, "t5");

        // random traffic
        for (int i = 0; i < 10000; i++) begin
            cycle(($urandom_range(0, 3) != 0), 16'($urandom), 16'($urandom),
                  ($urandom_range(0, 2) != 0), ($urandom_range(0, 31) == 0), "t6");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
